// File: rtl/tail_light_seq_if.sv
// Switch-request and lamp-drive bundle between the switch debouncers and the tail-light sequencer.
// The master drives requests and observes lamps; the slave is the sequencer itself.
interface tail_light_seq_if #(
    parameter int LAMPS = 3
);
    logic             left;
    logic             right;
    logic             hazard;
    logic             brake;
    logic [LAMPS-1:0] l;
    logic [LAMPS-1:0] r;
    logic             busy;

    modport master (
        output left, right, hazard, brake,
        input  l, r, busy
    );

    modport slave (
        input  left, right, hazard, brake,
        output l, r, busy
    );
endinterface

// File: rtl/tail_light_seq.sv
// Parametrised turn-signal / hazard / brake sequencer for LAMPS lamps per side.
// Sequence steps advance on an internal clock-enable tick; lamps are registered and track brake every clk.
module tail_light_seq #(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic           clk,
    input  logic           reset,
    tail_light_seq_if.slave bus
);

    localparam int                STEP_W    = $clog2(LAMPS);
    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(LAMPS - 1);
    localparam logic [LAMPS-1:0]  ALL_ON    = '1;
    localparam logic [LAMPS-1:0]  ALL_OFF   = '0;

    typedef enum logic [2:0] {
        IDLE,
        LSEQ,
        RSEQ,
        HAZ_ON,
        HAZ_OFF
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_L,
        REQ_R,
        REQ_HAZ
    } req_t;

    logic [CNT_W-1:0]  tick_cnt_q;
    logic [CNT_W-1:0]  tick_cnt_d;
    logic              tick;
    state_t            state_q;
    state_t            state_d;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_d;
    req_t              req;
    logic [LAMPS-1:0]  seq_l;
    logic [LAMPS-1:0]  seq_r;
    logic [LAMPS-1:0]  l_q;
    logic [LAMPS-1:0]  l_d;
    logic [LAMPS-1:0]  r_q;
    logic [LAMPS-1:0]  r_d;
    logic              busy_q;
    logic              busy_d;

    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
    end

    // Hazard outranks both turn requests; both turn switches together cancel out.
    always_comb begin
        req = REQ_NONE;
        if (bus.hazard) begin
            req = REQ_HAZ;
        end else if (bus.left && !bus.right) begin
            req = REQ_L;
        end else if (bus.right && !bus.left) begin
            req = REQ_R;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    step_d = '0;
                    case (req)
                        REQ_HAZ: state_d = HAZ_ON;
                        REQ_L:   state_d = LSEQ;
                        REQ_R:   state_d = RSEQ;
                        default: state_d = IDLE;
                    endcase
                end
                LSEQ: begin
                    if (req == REQ_HAZ) begin
                        state_d = HAZ_ON;
                        step_d  = '0;
                    end else if (req == REQ_L && step_q != STEP_LAST) begin
                        step_d = step_q + STEP_W'(1);
                    end else begin
                        state_d = IDLE;
                        step_d  = '0;
                    end
                end
                RSEQ: begin
                    if (req == REQ_HAZ) begin
                        state_d = HAZ_ON;
                        step_d  = '0;
                    end else if (req == REQ_R && step_q != STEP_LAST) begin
                        step_d = step_q + STEP_W'(1);
                    end else begin
                        state_d = IDLE;
                        step_d  = '0;
                    end
                end
                HAZ_ON: begin
                    state_d = (req == REQ_HAZ) ? HAZ_OFF : IDLE;
                    step_d  = '0;
                end
                HAZ_OFF: begin
                    state_d = (req == REQ_HAZ) ? HAZ_ON : IDLE;
                    step_d  = '0;
                end
                default: begin
                    state_d = IDLE;
                    step_d  = '0;
                end
            endcase
        end
    end

    // Left fills outward from bit 0, right fills outward from bit LAMPS-1.
    always_comb begin
        seq_l = '0;
        seq_r = '0;
        for (int i = 0; i < LAMPS; i++) begin
            seq_l[i] = (STEP_W'(i) <= step_q);
            seq_r[i] = (STEP_W'(LAMPS - 1 - i) <= step_q);
        end
    end

    always_comb begin
        l_d    = ALL_OFF;
        r_d    = ALL_OFF;
        busy_d = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                l_d = bus.brake ? ALL_ON : ALL_OFF;
                r_d = bus.brake ? ALL_ON : ALL_OFF;
            end
            LSEQ: begin
                l_d = seq_l;
                r_d = bus.brake ? ALL_ON : ALL_OFF;
            end
            RSEQ: begin
                l_d = bus.brake ? ALL_ON : ALL_OFF;
                r_d = seq_r;
            end
            HAZ_ON: begin
                l_d = ALL_ON;
                r_d = ALL_ON;
            end
            default: begin
                l_d = ALL_OFF;
                r_d = ALL_OFF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_q <= '0;
            state_q    <= IDLE;
            step_q     <= '0;
            l_q        <= '0;
            r_q        <= '0;
            busy_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            step_q     <= step_d;
            l_q        <= l_d;
            r_q        <= r_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.l    = l_q;
    assign bus.r    = r_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_tail_light_seq.sv
// Bench for tail_light_seq: directed vector table, async-reset and LAMPS=5 sequences,
// and randomized requests compared every cycle against a lamp-count reference model.
module tb_tail_light_seq;

    localparam int TL  = 3;
    localparam int TL5 = 5;
    localparam int TD  = 4;
    localparam int CW  = 3;

    localparam logic [3:0] I_N = 4'b0000;
    localparam logic [3:0] I_L = 4'b1000;
    localparam logic [3:0] I_R = 4'b0100;
    localparam logic [3:0] I_H = 4'b0010;
    localparam logic [3:0] I_B = 4'b0001;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    tail_light_seq_if #(.LAMPS(TL))  if3 ();
    tail_light_seq_if #(.LAMPS(TL5)) if5 ();

    tail_light_seq #(.LAMPS(TL), .TICK_DIV(TD), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (if3)
    );

    tail_light_seq #(.LAMPS(TL5), .TICK_DIV(TD), .CNT_W(CW)) dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (if5)
    );

    // Reference: which side is lit and how many lamps, rather than a state/step pair.
    typedef enum int {SIDE_NONE, SIDE_LEFT, SIDE_RIGHT, SIDE_BOTH} side_t;

    side_t           m_side;
    int              m_lit;
    int              m_cyc;
    logic [TL-1:0]   m_l;
    logic [TL-1:0]   m_r;
    logic            m_busy;

    function automatic logic [TL-1:0] fill_low(input int n);
        logic [31:0] w;
        w = (32'd1 << n) - 32'd1;
        return w[TL-1:0];
    endfunction

    function automatic logic [TL-1:0] fill_high(input int n);
        logic [31:0] w;
        w = ((32'd1 << n) - 32'd1) << (TL - n);
        return w[TL-1:0];
    endfunction

    function automatic logic [TL-1:0] exp_left(input side_t s, input int lit, input logic bk);
        logic [TL-1:0] v;
        v = '0;
        if (s == SIDE_LEFT || s == SIDE_BOTH) v = fill_low(lit);
        if (bk && (s == SIDE_NONE || s == SIDE_RIGHT)) v = '1;
        return v;
    endfunction

    function automatic logic [TL-1:0] exp_right(input side_t s, input int lit, input logic bk);
        logic [TL-1:0] v;
        v = '0;
        if (s == SIDE_RIGHT) v = fill_high(lit);
        if (s == SIDE_BOTH)  v = fill_low(lit);
        if (bk && (s == SIDE_NONE || s == SIDE_LEFT)) v = '1;
        return v;
    endfunction

    function automatic int request(input logic lf, input logic rt, input logic hz);
        if (hz) return 3;
        if (lf && !rt) return 1;
        if (rt && !lf) return 2;
        return 0;
    endfunction

    function automatic int next_code(input side_t s, input int lit, input int req);
        if (req == 3) return (s == SIDE_BOTH && lit == TL) ? int'(SIDE_BOTH) * 16 : int'(SIDE_BOTH) * 16 + TL;
        if (s == SIDE_NONE) begin
            if (req == 1) return int'(SIDE_LEFT) * 16 + 1;
            if (req == 2) return int'(SIDE_RIGHT) * 16 + 1;
            return 0;
        end
        if (s == SIDE_LEFT && req == 1 && lit < TL) return int'(SIDE_LEFT) * 16 + lit + 1;
        if (s == SIDE_RIGHT && req == 2 && lit < TL) return int'(SIDE_RIGHT) * 16 + lit + 1;
        return 0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_side <= SIDE_NONE;
            m_lit  <= 0;
            m_cyc  <= 0;
            m_l    <= '0;
            m_r    <= '0;
            m_busy <= 1'b0;
        end else begin
            m_l    <= exp_left(m_side, m_lit, if3.brake);
            m_r    <= exp_right(m_side, m_lit, if3.brake);
            m_busy <= (m_side != SIDE_NONE);
            m_cyc  <= (m_cyc == TD - 1) ? 0 : m_cyc + 1;
            if (m_cyc == TD - 1) begin
                m_side <= side_t'(next_code(m_side, m_lit, request(if3.left, if3.right, if3.hazard)) / 16);
                m_lit  <= next_code(m_side, m_lit, request(if3.left, if3.right, if3.hazard)) % 16;
            end
        end
    end

    typedef struct {
        logic       rst;
        logic [3:0] in;
        int         n;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check_output(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_output("model", {9'd0, if3.l, if3.r, if3.busy}, {9'd0, m_l, m_r, m_busy});
    endtask

    task automatic apply_stimulus(input logic [3:0] in);
        {if3.left, if3.right, if3.hazard, if3.brake} = in;
    endtask

    task automatic do_reset(input logic [3:0] in);
        @(negedge clk);
        reset = 1'b0;
        apply_stimulus(in);
        step();
        step();
        check_output("reset", {9'd0, if3.l, if3.r, if3.busy}, 16'd0);
        reset = 1'b1;
    endtask

    task automatic add(input logic rs, input logic [3:0] in, input int n, input logic [6:0] exp);
        vec_t v;
        v.rst = rs;
        v.in  = in;
        v.n   = n;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        logic [3:0] rin;
        int         w5;

        apply_stimulus(I_N);
        {if5.left, if5.right, if5.hazard, if5.brake} = 4'b0000;

        // Columns: reset-first, inputs, clocks to advance, expected {l, r, busy}.
        add(1'b1, I_L,             4, 7'b000_000_0);
        add(1'b0, I_L,             1, 7'b001_000_1);
        add(1'b0, I_L,             3, 7'b001_000_1);
        add(1'b0, I_L,             1, 7'b011_000_1);
        add(1'b0, I_L,             4, 7'b111_000_1);
        add(1'b0, I_L,             4, 7'b000_000_0);
        add(1'b0, I_L,             4, 7'b001_000_1);
        add(1'b1, I_R | I_B,       1, 7'b111_111_0);
        add(1'b0, I_R | I_B,       4, 7'b111_100_1);
        add(1'b0, I_R | I_B,       4, 7'b111_110_1);
        add(1'b0, I_R | I_B,       4, 7'b111_111_1);
        add(1'b0, I_R | I_B,       1, 7'b111_111_1);
        add(1'b0, I_R,             1, 7'b000_111_1);
        add(1'b0, I_R,             2, 7'b000_000_0);
        add(1'b1, I_L,             9, 7'b011_000_1);
        add(1'b0, I_R,             4, 7'b000_000_0);
        add(1'b0, I_R,             4, 7'b000_100_1);
        add(1'b1, I_L | I_R,      12, 7'b000_000_0);
        add(1'b1, I_L,             5, 7'b001_000_1);
        add(1'b0, I_L | I_H,       4, 7'b111_111_1);
        add(1'b0, I_L | I_H,       4, 7'b000_000_1);
        add(1'b0, I_L | I_H,       4, 7'b111_111_1);
        add(1'b0, I_L | I_H,       4, 7'b000_000_1);
        add(1'b0, I_L | I_H | I_B, 2, 7'b000_000_1);
        add(1'b0, I_N,             1, 7'b000_000_1);
        add(1'b0, I_N,             1, 7'b000_000_0);
        add(1'b1, I_N,             4, 7'b000_000_0);
        add(1'b0, I_L,             2, 7'b000_000_0);
        add(1'b0, I_N,             6, 7'b000_000_0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset(vecs[i].in);
            apply_stimulus(vecs[i].in);
            repeat (vecs[i].n) step();
            check_output($sformatf("vec%0d", i), {9'd0, if3.l, if3.r, if3.busy}, {9'd0, vecs[i].exp});
        end

        // Reset pulled between clock edges must clear outputs with no edge.
        do_reset(I_R);
        repeat (10) step();
        check_output("rseq_step1", {9'd0, if3.l, if3.r, if3.busy}, {9'd0, 7'b000_110_1});
        #2 reset = 1'b0;
        #1 check_output("async_reset", {9'd0, if3.l, if3.r, if3.busy}, 16'd0);
        step();
        reset = 1'b1;
        repeat (4) step();
        check_output("post_reset_c4", {9'd0, if3.l, if3.r, if3.busy}, {9'd0, 7'b000_000_0});
        step();
        check_output("post_reset_c5", {9'd0, if3.l, if3.r, if3.busy}, {9'd0, 7'b000_100_1});

        if5.left = 1'b1;
        do_reset(I_N);
        repeat (5) step();
        for (int k = 1; k <= TL5 + 1; k++) begin
            if (k > 1) repeat (4) step();
            w5 = (k <= TL5) ? (1 << k) - 1 : 0;
            check_output($sformatf("lamps5_k%0d", k), {5'd0, if5.l, if5.r, if5.busy},
                         {5'd0, 5'(w5), 5'b00000, (k <= TL5)});
        end
        if5.left = 1'b0;

        do_reset(I_N);
        for (int seg = 0; seg < 120; seg++) begin
            if ($urandom_range(0, 29) == 0) begin
                reset = 1'b0;
                step();
                reset = 1'b1;
            end
            rin = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) rin[1] = 1'b0;
            apply_stimulus(rin);
            repeat ($urandom_range(1, 16)) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
